// File: rtl/eth_hdr_pkg.sv
// Shared types and constants for the Ethernet header parser: FSM states,
// framing bytes, error codes and default length/EtherType thresholds.
`timescale 1ns/1ps
package eth_hdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DST  = 2'b01;
  localparam logic [1:0] ERR_SRC  = 2'b10;
  localparam logic [1:0] ERR_TYPE = 2'b11;

  localparam int          DEFAULT_MAX_LEN       = 1500;
  localparam logic [15:0] DEFAULT_ETHERTYPE_MIN = 16'h0600;
  localparam logic [3:0]  PREAMBLE_SAT          = 4'd15;

endpackage

// File: rtl/eth_field_capture.sv
// N-byte header field: MSB-first shift capture plus a compare of the incoming
// byte against the configured byte selected by the parser's byte index.
`timescale 1ns/1ps
module eth_field_capture #(
  parameter int N = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           shift,
  input  logic [2:0]     idx,
  input  logic [7:0]     data,
  input  logic [8*N-1:0] cfg,
  output logic           match,
  output logic           last,
  output logic [8*N-1:0] value
);

  logic [7:0] cfg_byte;

  // NOTE: cfg_byte gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    cfg_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == 3'(i)) cfg_byte = cfg[8*(N-1-i) +: 8];
    end
  end

  assign match = (data == cfg_byte);
  assign last  = (idx == 3'(N-1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      value <= '0;
    else if (clear) value <= '0;
    else if (shift) value <= {value[8*N-9:0], data};
  end

endmodule

// File: rtl/eth_header_parser.sv
// Ethernet header parser: preamble/SFD detection, dst/src/type capture with
// configurable checks, and payload framing for length-mode frames.
`timescale 1ns/1ps
module eth_header_parser
  import eth_hdr_pkg::*;
#(
  parameter int          PREAMBLE_MIN  = 7,
  parameter int          MAX_LEN       = DEFAULT_MAX_LEN,
  parameter logic [15:0] ETHERTYPE_MIN = DEFAULT_ETHERTYPE_MIN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        data_valid,
  input  logic [7:0]  data,
  input  logic        cfg_promisc,
  input  logic        cfg_src_check,
  input  logic        cfg_type_check,
  input  logic [47:0] cfg_dst_addr,
  input  logic [47:0] cfg_src_addr,
  input  logic [15:0] cfg_type,
  output logic        preamble_valid,
  output logic        dst_addr_valid,
  output logic        src_addr_valid,
  output logic        type_length_valid,
  output logic [47:0] dst_addr,
  output logic [47:0] src_addr,
  output logic [15:0] type_length,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        hdr_done,
  output logic        hdr_error,
  output logic [1:0]  err_code
);

  state_t      state;
  logic [2:0]  idx;
  logic [3:0]  pre_cnt;
  logic [10:0] pay_cnt;
  logic        len_mode;

  logic consume;
  logic dst_match, dst_last, src_match, src_last, type_match, type_last;
  logic cur_chk, cur_match, cur_last;
  logic [1:0]  cur_code;
  logic [15:0] tl_next;

  assign consume = enable && data_valid;
  assign tl_next = {type_length[7:0], data};

  eth_field_capture #(.N(6)) u_dst (
    .clock(clock), .reset(reset), .clear(!enable),
    .shift(consume && state == ST_DST), .idx(idx), .data(data),
    .cfg(cfg_dst_addr), .match(dst_match), .last(dst_last), .value(dst_addr)
  );

  eth_field_capture #(.N(6)) u_src (
    .clock(clock), .reset(reset), .clear(!enable),
    .shift(consume && state == ST_SRC), .idx(idx), .data(data),
    .cfg(cfg_src_addr), .match(src_match), .last(src_last), .value(src_addr)
  );

  eth_field_capture #(.N(2)) u_type (
    .clock(clock), .reset(reset), .clear(!enable),
    .shift(consume && state == ST_TYPE), .idx(idx), .data(data),
    .cfg(cfg_type), .match(type_match), .last(type_last), .value(type_length)
  );

  // Route the active field's compare result so the FSM handles all three alike.
  always_comb begin
    cur_chk   = 1'b0;
    cur_match = 1'b1;
    cur_last  = 1'b0;
    cur_code  = ERR_NONE;
    case (state)
      ST_DST:  begin cur_chk = !cfg_promisc;   cur_match = dst_match;  cur_last = dst_last;  cur_code = ERR_DST;  end
      ST_SRC:  begin cur_chk = cfg_src_check;  cur_match = src_match;  cur_last = src_last;  cur_code = ERR_SRC;  end
      ST_TYPE: begin cur_chk = cfg_type_check; cur_match = type_match; cur_last = type_last; cur_code = ERR_TYPE; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      pre_cnt           <= '0;
      pay_cnt           <= '0;
      len_mode          <= 1'b0;
      preamble_valid    <= 1'b0;
      dst_addr_valid    <= 1'b0;
      src_addr_valid    <= 1'b0;
      type_length_valid <= 1'b0;
      payload_valid     <= 1'b0;
      payload_last      <= 1'b0;
      hdr_done          <= 1'b0;
      hdr_error         <= 1'b0;
      err_code          <= ERR_NONE;
    end else if (!enable) begin
      state             <= ST_IDLE;
      idx               <= '0;
      pre_cnt           <= '0;
      pay_cnt           <= '0;
      len_mode          <= 1'b0;
      preamble_valid    <= 1'b0;
      dst_addr_valid    <= 1'b0;
      src_addr_valid    <= 1'b0;
      type_length_valid <= 1'b0;
      payload_valid     <= 1'b0;
      payload_last      <= 1'b0;
      hdr_done          <= 1'b0;
      hdr_error         <= 1'b0;
      err_code          <= ERR_NONE;
    end else begin
      preamble_valid    <= 1'b0;
      dst_addr_valid    <= 1'b0;
      src_addr_valid    <= 1'b0;
      type_length_valid <= 1'b0;
      payload_valid     <= 1'b0;
      payload_last      <= 1'b0;
      hdr_done          <= 1'b0;
      hdr_error         <= 1'b0;

      if (data_valid) begin
        case (state)
          ST_IDLE: begin
            if (data == PREAMBLE_BYTE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 4'd1;
            end
          end

          ST_PREAMBLE: begin
            if (data == PREAMBLE_BYTE) begin
              if (pre_cnt != PREAMBLE_SAT) pre_cnt <= pre_cnt + 4'd1;
            end else if (data == SFD_BYTE && pre_cnt >= 4'(PREAMBLE_MIN)) begin
              preamble_valid <= 1'b1;
              idx            <= '0;
              state          <= ST_DST;
            end else begin
              state <= ST_IDLE;
            end
          end

          ST_DST, ST_SRC, ST_TYPE: begin
            if (cur_chk && !cur_match) begin
              hdr_error <= 1'b1;
              err_code  <= cur_code;
              idx       <= '0;
              // A stray preamble byte is likely the start of the next frame.
              if (data == PREAMBLE_BYTE) begin
                state   <= ST_PREAMBLE;
                pre_cnt <= 4'd1;
              end else begin
                state <= ST_IDLE;
              end
            end else if (!cur_last) begin
              idx <= idx + 3'd1;
            end else begin
              idx <= '0;
              case (state)
                ST_DST: begin
                  dst_addr_valid <= 1'b1;
                  state          <= ST_SRC;
                end
                ST_SRC: begin
                  src_addr_valid <= 1'b1;
                  state          <= ST_TYPE;
                end
                default: begin
                  if (tl_next == 16'd0) begin
                    type_length_valid <= 1'b1;
                    hdr_done          <= 1'b1;
                    state             <= ST_IDLE;
                  end else if (tl_next <= 16'(MAX_LEN)) begin
                    type_length_valid <= 1'b1;
                    hdr_done          <= 1'b1;
                    pay_cnt           <= tl_next[10:0];
                    len_mode          <= 1'b1;
                    state             <= ST_PAYLOAD;
                  end else if (tl_next >= ETHERTYPE_MIN) begin
                    type_length_valid <= 1'b1;
                    hdr_done          <= 1'b1;
                    len_mode          <= 1'b0;
                    state             <= ST_PAYLOAD;
                  end else begin
                    hdr_error <= 1'b1;
                    err_code  <= ERR_TYPE;
                    state     <= ST_IDLE;
                  end
                end
              endcase
            end
          end

          ST_PAYLOAD: begin
            payload_valid <= 1'b1;
            if (len_mode) begin
              pay_cnt <= pay_cnt - 11'd1;
              if (pay_cnt == 11'd1) begin
                payload_last <= 1'b1;
                state        <= ST_IDLE;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed bench for eth_header_parser: preamble rules, field compares,
// resynchronisation, length/type payload handling, reset and enable drop.
`timescale 1ns/1ps
module tb_eth_header_parser;
  import eth_hdr_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        data_valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        cfg_promisc = 1'b0;
  logic        cfg_src_check = 1'b1;
  logic        cfg_type_check = 1'b1;
  logic [47:0] cfg_dst_addr = 48'h010203040506;
  logic [47:0] cfg_src_addr = 48'hFFFEFDFCFBFA;
  logic [15:0] cfg_type = 16'h0800;

  logic        preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid;
  logic [47:0] dst_addr, src_addr;
  logic [15:0] type_length;
  logic        payload_valid, payload_last, hdr_done, hdr_error;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_err = 0;

  eth_header_parser #(.PREAMBLE_MIN(7)) dut (
    .clock(clock), .reset(reset), .enable(enable), .data_valid(data_valid), .data(data),
    .cfg_promisc(cfg_promisc), .cfg_src_check(cfg_src_check), .cfg_type_check(cfg_type_check),
    .cfg_dst_addr(cfg_dst_addr), .cfg_src_addr(cfg_src_addr), .cfg_type(cfg_type),
    .preamble_valid(preamble_valid), .dst_addr_valid(dst_addr_valid),
    .src_addr_valid(src_addr_valid), .type_length_valid(type_length_valid),
    .dst_addr(dst_addr), .src_addr(src_addr), .type_length(type_length),
    .payload_valid(payload_valid), .payload_last(payload_last),
    .hdr_done(hdr_done), .hdr_error(hdr_error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  wire [7:0] pulses = {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
                       payload_valid, payload_last, hdr_done, hdr_error};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    data       = b;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic gap();
    @(negedge clock);
    data_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic send48(input logic [47:0] v);
    for (int i = 5; i >= 0; i--) send(v[8*i +: 8]);
  endtask

  task automatic send16(input logic [15:0] v);
    send(v[15:8]);
    send(v[7:0]);
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) send(PREAMBLE_BYTE);
    send(SFD_BYTE);
  endtask

  task automatic send_frame(input int n, input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t);
    send_pre(n);
    send48(d);
    send48(s);
    send16(t);
  endtask

  // Enable low with a byte offered at the same edge: the byte is dropped.
  task automatic drop_enable(input string tag);
    @(negedge clock);
    enable     = 1'b0;
    data       = 8'h33;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    check({tag, "_pulses"}, pulses, 0);
    check({tag, "_addrs"}, {dst_addr, src_addr} == 96'd0, 1);
    check({tag, "_tl_err"}, {type_length, err_code}, 0);
    @(negedge clock);
    enable     = 1'b1;
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_pulses", pulses, 0);
    check("rst_fields", {dst_addr, type_length, err_code}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Nominal frame, EtherType 0x0800.
    for (int i = 0; i < 7; i++) send(PREAMBLE_BYTE);
    check("pre_not_yet", preamble_valid, 0);
    send(SFD_BYTE);
    check("pre_valid", preamble_valid, 1);
    send48(48'h010203040506);
    check("dst_valid", {preamble_valid, dst_addr_valid}, 2'b01);
    check("dst_addr", dst_addr, 48'h010203040506);
    send48(48'hFFFEFDFCFBFA);
    check("src_valid", {dst_addr_valid, src_addr_valid}, 2'b01);
    check("src_addr", src_addr, 48'hFFFEFDFCFBFA);
    send(8'h08);
    check("tl_partial", type_length_valid, 0);
    send(8'h00);
    check("tl_done", {type_length_valid, hdr_done, hdr_error, src_addr_valid}, 4'b1100);
    check("tl_value", type_length, 16'h0800);
    send(8'hAA);
    check("pay_v1", payload_valid, 1);
    gap();
    check("pay_gap", payload_valid, 0);
    send(8'hBB);
    check("pay_v2", {payload_valid, payload_last}, 2'b10);
    drop_enable("en_drop1");

    // Preamble length rules.
    send_pre(10);
    check("pre10", preamble_valid, 1);
    drop_enable("en_drop2");
    send_pre(5);
    check("pre5", preamble_valid, 0);
    send48(48'h010203040506);
    check("pre5_idle", {dst_addr_valid, hdr_error}, 0);
    check("pre5_nocap", dst_addr, 0);

    // Dst mismatch on a 0x55 byte, then resynchronise on it.
    send_pre(7);
    send(8'h01); send(8'h02); send(8'h03); send(8'h55);
    check("dst_err", {hdr_error, err_code}, {1'b1, ERR_DST});
    for (int i = 0; i < 6; i++) send(PREAMBLE_BYTE);
    send(SFD_BYTE);
    check("resync_pre", preamble_valid, 1);
    send48(48'h010203040506);
    send48(48'hFFFEFDFCFBFA);
    send16(16'h0800);
    check("resync_done", {hdr_done, hdr_error}, 2'b10);
    check("err_held", err_code, ERR_DST);
    drop_enable("en_drop3");

    // Length mode: three payload bytes with gaps.
    cfg_type_check = 1'b0;
    send_frame(7, 48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0003);
    check("len_done", {hdr_done, type_length_valid}, 2'b11);
    check("len_value", type_length, 16'h0003);
    send(8'hA0);
    check("len_b1", {payload_valid, payload_last}, 2'b10);
    gap();
    send(8'hA1);
    check("len_b2", {payload_valid, payload_last}, 2'b10);
    gap();
    gap();
    send(8'hA2);
    check("len_b3", {payload_valid, payload_last}, 2'b11);
    send(8'h11);
    check("len_idle", {payload_valid, payload_last}, 2'b00);

    // Illegal length/type value between MAX_LEN and ETHERTYPE_MIN.
    send_frame(7, 48'h010203040506, 48'hFFFEFDFCFBFA, 16'h05FF);
    check("illegal_tl", {hdr_error, hdr_done, err_code}, {2'b10, ERR_TYPE});
    send(8'h22);
    check("illegal_idle", payload_valid, 0);

    // Promiscuous, no source check, zero type/length.
    cfg_promisc   = 1'b1;
    cfg_src_check = 1'b0;
    send_pre(7);
    send48(48'h112233445566);
    check("prom_dst", {dst_addr_valid, hdr_error}, 2'b10);
    check("prom_dst_addr", dst_addr, 48'h112233445566);
    send48(48'hA1B2C3D4E5F6);
    check("prom_src", {src_addr_valid, hdr_error}, 2'b10);
    check("prom_src_addr", src_addr, 48'hA1B2C3D4E5F6);
    send16(16'h0000);
    check("zero_tl", {hdr_done, hdr_error}, 2'b10);
    check("err_held2", err_code, ERR_TYPE);
    send(8'h44);
    check("zero_idle", payload_valid, 0);

    // Asynchronous reset in SRC.
    cfg_promisc    = 1'b0;
    cfg_src_check  = 1'b1;
    cfg_type_check = 1'b1;
    send_pre(7);
    send48(48'h010203040506);
    send(8'hFF);
    send(8'hFE);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pulses", pulses, 0);
    check("arst_fields", {dst_addr, src_addr[15:0], err_code}, 0);
    @(negedge clock);
    reset = 1'b0;
    send(SFD_BYTE);
    check("arst_no_pre", preamble_valid, 0);
    send_frame(7, 48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800);
    check("arst_frame", {hdr_done, hdr_error, type_length}, {2'b10, 16'h0800});

    // Enable drop in type-mode PAYLOAD, then a normal frame.
    send(8'h5A);
    check("pay_before_drop", payload_valid, 1);
    drop_enable("en_drop4");
    send(8'h00);
    check("drop_idle", payload_valid, 0);
    send_frame(7, 48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800);
    check("post_drop_frame", {hdr_done, hdr_error}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_header_parser.md
# eth_header_parser

Parametrised, error-reporting successor to the Ethernet header FSM. Consumes a byte stream qualified by a per-byte strobe, detects a variable-length preamble plus SFD, then captures and checks destination, source and type/length against runtime-configurable values, and walks the payload when the field is a length. It sits between the byte-level receive front end and the frame buffer/filter logic. Its outputs are field-valid pulses, captured header fields, payload framing and error codes.

## Interface
- PREAMBLE_MIN, 7: minimum count of 0x55 bytes before SFD 0xD5 is accepted; range 1..15.
- MAX_LEN, 1500: largest type/length value treated as a payload length.
- ETHERTYPE_MIN, 16'h0600: smallest value treated as an EtherType.
- clock  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- enable  in  1  synchronous gate; low returns the parser to IDLE and clears outputs at the next edge.
- data_valid  in  1  a byte is consumed only when enable && data_valid.
- data  in  8  stream byte.
- cfg_promisc  in  1  1 = skip destination compare.
- cfg_src_check  in  1  1 = compare source against cfg_src_addr.
- cfg_type_check  in  1  1 = compare type/length against cfg_type.
- cfg_dst_addr, cfg_src_addr  in  48  expected addresses; the first byte on the wire is bits [47:40].
- cfg_type  in  16  expected type/length; the first byte is bits [15:8].
- preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid  out  1  one-cycle pulses.
- dst_addr, src_addr  out  48  captured addresses.
- type_length  out  16  captured field.
- payload_valid  out  1  registered copy of the consume strobe while in PAYLOAD.
- payload_last  out  1  pulse with the final length-mode payload byte.
- hdr_done  out  1  pulse when the type/length field is accepted.
- hdr_error  out  1  one-cycle pulse.
- err_code  out  2  01 dst mismatch, 10 src mismatch, 11 type mismatch or illegal length; holds until the next error or reset.

## Operation
- States: IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD. A 3-bit byte index counts within a field. A 4-bit saturating preamble counter and an 11-bit payload counter run alongside.
- IDLE: 0x55 goes to PREAMBLE with count=1. Any other byte stays in IDLE.
- PREAMBLE:
  - 0x55 increments the count, saturating at 15.
  - 0xD5 with count >= PREAMBLE_MIN pulses preamble_valid and goes to DST.
  - 0xD5 with count < PREAMBLE_MIN goes to IDLE with no error.
  - Any other byte goes to IDLE.
- DST, SRC, TYPE: each byte shifts into its capture register, MSB first.
  - If the compare is enabled and the byte differs from the config byte at the current index, pulse hdr_error, set err_code, and go to IDLE.
  - A mismatching byte equal to 0x55 instead goes to PREAMBLE with count=1 (resynchronisation). The error is still reported.
  - After the last byte of the field (6/6/2), pulse the field valid and advance.
- TYPE completion (the value is checked after the compare):
  - 0: hdr_done, then IDLE.
  - 1..MAX_LEN: hdr_done, load the payload counter, go to PAYLOAD (length mode).
  - >= ETHERTYPE_MIN: hdr_done, go to PAYLOAD (type mode).
  - Otherwise: hdr_error with code 11, then IDLE.
- PAYLOAD, length mode: each consumed byte decrements the counter. On the byte that takes it to 0, pulse payload_last and go to IDLE.
- PAYLOAD, type mode: stays in PAYLOAD until enable goes low.
- Cycles with data_valid low hold all state. Pulses are not re-asserted.
- Captured fields hold their value until the first byte of the same field in the next frame.
- cfg_* inputs are sampled per byte. Software changes them only in IDLE. A change mid-frame applies from the next byte compared.

## Timing
- Every output is registered and is 0 on reset and on enable low (dst_addr, src_addr and type_length also clear to 0).
- Latency: the byte consumed at edge N produces its pulse/status visible from edge N to edge N+1, for exactly one cycle.
- preamble_valid and dst/src/type valids never overlap. type_length_valid and hdr_done assert in the same cycle.
- Asynchronous reset mid-frame goes to IDLE immediately. The next frame requires a full preamble.
- enable low and data_valid high at the same edge: enable wins and the byte is dropped.

## Structure
- Package eth_hdr_pkg: state enum, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, err_code constants, default MAX_LEN and ETHERTYPE_MIN.
- Sub-module eth_field_capture, parametrised by byte count N:
  - shift register plus indexed byte compare;
  - outputs: match, last, value;
  - instantiated three times (N=6, 6, 2).

## Test plan
- Seven 0x55, then D5, 010203040506, FFFEFDFCFBFA, 0800, cfg matching → four valid pulses on successive byte cycles, hdr_done, type mode, payload_valid follows data_valid.
- Ten 0x55 then D5 → accepted. Five 0x55 then D5 with PREAMBLE_MIN=7 → no preamble_valid, parser back in IDLE.
- Dst byte 4 = 0x55 instead of 0x04, not promiscuous → hdr_error, err_code=01, then a full valid frame starting with that byte's successors (six more 0x55, then D5) is accepted.
- Type/length 0x0003 followed by 3 payload bytes with data_valid gaps → payload_last on the 3rd byte, then IDLE. Type/length 0x05FF → err_code=11.
- cfg_promisc=1 and cfg_src_check=0 with arbitrary addresses → dst/src captured (dst_addr = the bytes received), no error.
- Reset asserted asynchronously in SRC, and enable dropped in PAYLOAD → all outputs 0, state IDLE, next frame parsed normally.
